// File: rtl/vga_plot_sched.sv
// Pixel-plot scheduler: bus staging registers, plot FIFO, full-screen fill engine,
// and arbitration of the single VGA adapter port between queued plots and fills.
module vga_plot_sched #(
  parameter int XW    = 8,
  parameter int YW    = 7,
  parameter int CW    = 9,
  parameter int DEPTH = 4,
  parameter int XMAX  = 160,
  parameter int YMAX  = 120
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          cs,
  input  logic          W,
  input  logic [4:0]    addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata,
  output logic          stall,
  output logic [XW-1:0] vga_x,
  output logic [YW-1:0] vga_y,
  output logic [CW-1:0] vga_colour,
  output logic          vga_plot,
  input  logic          vga_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int NW = AW + 1;
  localparam int EW = XW + YW + CW;

  localparam logic [4:0] A_X      = 5'h00;
  localparam logic [4:0] A_Y      = 5'h04;
  localparam logic [4:0] A_COL    = 5'h08;
  localparam logic [4:0] A_PLOT   = 5'h0C;
  localparam logic [4:0] A_FILL   = 5'h10;
  localparam logic [4:0] A_STATUS = 5'h14;

  typedef enum logic [1:0] {S_IDLE, S_PIXEL, S_FILL} state_t;

  state_t        r_state;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_fill_col;
  logic          r_fill_pending;

  logic [EW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [NW-1:0] r_count;

  logic          w_wr_plot;
  logic          w_wr_fill;
  logic          w_fill_busy;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_fill_go;
  logic          w_accept;
  logic          w_pop;
  logic          w_last_px;
  logic [EW-1:0] w_head;
  logic          w_unused;

  assign w_unused    = ^wdata;
  assign w_wr_plot   = cs & W & (addr == A_PLOT);
  assign w_wr_fill   = cs & W & (addr == A_FILL);
  assign w_fill_busy = r_fill_pending | (r_state == S_FILL);
  assign w_full      = (r_count == NW'(DEPTH));
  assign w_empty     = (r_count == '0);

  // Full is judged on the pre-edge count, so a same-cycle pop never rescues a stalled PLOT.
  assign stall     = (w_wr_plot & (w_full | w_fill_busy)) | (w_wr_fill & w_fill_busy);
  assign w_push    = w_wr_plot & ~stall;
  assign w_fill_go = w_wr_fill & ~stall;

  assign w_accept  = vga_plot & vga_ready;
  assign w_pop     = ~w_empty & ((r_state == S_IDLE) | ((r_state == S_PIXEL) & w_accept));
  assign w_head    = r_mem[r_rptr];
  assign w_last_px = (vga_x == XW'(XMAX - 1)) & (vga_y == YW'(YMAX - 1));

  always_comb begin
    rdata = '0;
    if (cs & ~W & (addr == A_STATUS)) begin
      rdata[0]   = w_fill_busy;
      rdata[1]   = w_full;
      rdata[2]   = w_empty;
      rdata[7:4] = 4'(r_count);
    end
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_x   <= '0;
      r_y   <= '0;
      r_col <= '0;
    end else if (cs & W) begin
      if (addr == A_X)   r_x   <= wdata[XW-1:0];
      if (addr == A_Y)   r_y   <= wdata[YW-1:0];
      if (addr == A_COL) r_col <= wdata[CW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {r_x, r_y, r_col};
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Output registers double as the fill scan counters while in S_FILL.
  always_ff @(posedge clk) begin
    if (resetn) begin
      r_state        <= S_IDLE;
      r_fill_pending <= 1'b0;
      r_fill_col     <= '0;
      vga_x          <= '0;
      vga_y          <= '0;
      vga_colour     <= '0;
      vga_plot       <= 1'b0;
    end else begin
      if (w_fill_go) begin
        r_fill_pending <= 1'b1;
        r_fill_col     <= wdata[CW-1:0];
      end
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            {vga_x, vga_y, vga_colour} <= w_head;
            vga_plot <= 1'b1;
            r_state  <= S_PIXEL;
          end else if (r_fill_pending) begin
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= r_fill_col;
            vga_plot   <= 1'b1;
            r_state    <= S_FILL;
          end
        end
        S_PIXEL: begin
          if (w_accept) begin
            if (!w_empty) begin
              {vga_x, vga_y, vga_colour} <= w_head;
            end else begin
              vga_plot <= 1'b0;
              r_state  <= S_IDLE;
            end
          end
        end
        S_FILL: begin
          if (w_accept) begin
            if (w_last_px) begin
              vga_plot       <= 1'b0;
              r_fill_pending <= 1'b0;
              r_state        <= S_IDLE;
            end else if (vga_x == XW'(XMAX - 1)) begin
              vga_x <= '0;
              vga_y <= vga_y + 1'b1;
            end else begin
              vga_x <= vga_x + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_sched.sv
// Directed bench for vga_plot_sched: single plot, FIFO back-pressure, fills with
// steady and random ready, plot/fill ordering, and reset in the middle of a fill.
module tb_vga_plot_sched;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cs;
  logic        W;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [8:0]  vga_colour;
  logic        vga_plot;
  logic        vga_ready;
  logic [24:0] w_cur;

  int n_chk = 0;
  int n_err = 0;

  localparam int NPIX = 160 * 120;

  vga_plot_sched dut (
    .clk(clk), .resetn(resetn), .cs(cs), .W(W), .addr(addr), .wdata(wdata),
    .rdata(rdata), .stall(stall), .vga_x(vga_x), .vga_y(vga_y),
    .vga_colour(vga_colour), .vga_plot(vga_plot), .vga_ready(vga_ready)
  );

  always #5 clk = ~clk;
  assign w_cur = {vga_plot, vga_x, vga_y, vga_colour};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic [24:0] px(input int x, input int y, input int c);
    logic [7:0] xx;
    logic [6:0] yy;
    logic [8:0] cc;
    xx = 8'(x);
    yy = 7'(y);
    cc = 9'(c);
    return {1'b1, xx, yy, cc};
  endfunction

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; W = 1'b1; addr = a; wdata = d;
    @(posedge clk);
    #1 cs = 1'b0; W = 1'b0;
  endtask

  task automatic plot(input int x, input int y, input int c);
    wr(5'h00, 32'(x));
    wr(5'h04, 32'(y));
    wr(5'h08, 32'(c));
    wr(5'h0C, 32'hDEAD_BEEF);
  endtask

  task automatic status(input string tag, input logic [31:0] exp);
    @(negedge clk);
    cs = 1'b1; W = 1'b0; addr = 5'h14;
    #1 chk(tag, rdata, exp);
    cs = 1'b0;
  endtask

  // Expects a complete scan starting at (0,0); random ready exercises the hold rule.
  task automatic fill_scan(input bit rnd, input int col);
    int n = 0, ex = 0, ey = 0, cyc = 0;
    bit hold = 0;
    logic [24:0] held = '0;
    cs = 1'b1; W = 1'b0; addr = 5'h14;
    while (n < NPIX && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (hold) chk("fill_hold", 32'(w_cur), 32'(held));
      hold = 0;
      vga_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (vga_plot) begin
        if (vga_ready) begin
          chk("fill_px", 32'(w_cur), 32'(px(ex, ey, col)));
          if (n == NPIX - 1) chk("fill_busy_last", 32'(rdata[0]), 32'd1);
          n++;
          if (ex == 159) begin ex = 0; ey++; end else ex++;
        end else begin
          hold = 1;
          held = w_cur;
        end
      end
    end
    chk("fill_cnt", n, NPIX);
    @(negedge clk);
    chk("fill_done", {30'd0, vga_plot, rdata[0]}, 32'd0);
    cs = 1'b0;
    vga_ready = 1'b1;
  endtask

  initial begin
    int cyc;
    resetn = 1'b1; cs = 1'b0; W = 1'b0; addr = '0; wdata = '0; vga_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out", 32'(w_cur), 32'd0);
    chk("rst_rdata_nosel", rdata, 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    status("rst_status", 32'h4);
    @(negedge clk);
    cs = 1'b1; W = 1'b0; addr = 5'h18;
    #1 chk("unmapped_rd", rdata, 32'd0);
    cs = 1'b0;

    // Single plot: one cycle of vga_plot, one edge after the PLOT write
    plot(5, 7, 9'h1FF);
    @(negedge clk); chk("p1_pre", 32'(vga_plot), 32'd0);
    @(negedge clk); chk("p1_px", 32'(w_cur), 32'(px(5, 7, 9'h1FF)));
    @(negedge clk); chk("p1_post", 32'(vga_plot), 32'd0);

    // Back-pressure: output register plus four FIFO entries
    vga_ready = 1'b0;
    for (int i = 0; i < 5; i++) plot(10 + i, 20 + i, 9'h100 + i);
    status("bp_status_full", 32'h42);
    @(negedge clk);
    cs = 1'b1; W = 1'b1; addr = 5'h0C;
    #1 chk("bp_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1 cs = 1'b0; W = 1'b0;
    status("bp_status_after", 32'h42);
    @(negedge clk);
    chk("bp_hold", 32'(w_cur), 32'(px(10, 20, 9'h100)));
    vga_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_drain", 32'(w_cur), 32'(px(10 + i, 20 + i, 9'h100 + i)));
      @(negedge clk);
    end
    chk("bp_idle", 32'(vga_plot), 32'd0);

    // Steady fill
    wr(5'h10, 32'h0A4);
    fill_scan(1'b0, 9'h0A4);

    // Queued plots drain before the fill; plot and fill writes stall while fill is busy
    vga_ready = 1'b0;
    plot(1, 2, 9'h011);
    plot(3, 4, 9'h022);
    wr(5'h10, 32'h055);
    @(negedge clk);
    cs = 1'b1; W = 1'b1; addr = 5'h0C;
    #1 chk("ord_plot_stall", 32'(stall), 32'd1);
    addr = 5'h10; wdata = 32'h1FF;
    #1 chk("ord_fill_stall", 32'(stall), 32'd1);
    @(posedge clk);
    #1 cs = 1'b0; W = 1'b0;
    status("ord_status", 32'h11);
    @(negedge clk);
    vga_ready = 1'b1;
    chk("ord_p0", 32'(w_cur), 32'(px(1, 2, 9'h011)));
    @(negedge clk);
    chk("ord_p1", 32'(w_cur), 32'(px(3, 4, 9'h022)));
    fill_scan(1'b1, 9'h055);

    // Reset in the middle of a fill
    wr(5'h10, 32'h0A4);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!(vga_plot && vga_x == 8'd37 && vga_y == 7'd12) && cyc < 3000);
    chk("mid_reached", {vga_x, vga_y}, {8'd37, 7'd12});
    resetn = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    chk("mid_rst_out", 32'(w_cur), 32'd0);
    status("mid_rst_status", 32'h4);
    plot(33, 44, 9'h155);
    @(negedge clk); chk("mid_p_pre", 32'(vga_plot), 32'd0);
    @(negedge clk); chk("mid_p_px", 32'(w_cur), 32'(px(33, 44, 9'h155)));
    @(negedge clk); chk("mid_p_post", 32'(vga_plot), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
